// File: rtl/egress_serializer.sv
// Transmit side of the router serial port: buffers one parallel packet and shifts it out on frame_n/valid_n/dout.
// Define EGRESS_STATS_EN to add the pkt_count completed-packet counter.
module egress_serializer #(
   parameter int unsigned PAD_CYCLES = 0,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_addr,
   input  logic [31:0] in_data,
   output logic        frame_n,
   output logic        valid_n,
   output logic        dout,
   output logic        busy
`ifdef EGRESS_STATS_EN
   ,
   output logic [15:0] pkt_count
`endif
);

   typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, GAP} state_t;

   localparam logic [5:0] PAD_LAST = 6'(PAD_CYCLES - 1);
   localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

   state_t      state, state_nx;
   logic [5:0]  cnt, cnt_nx;
   logic        hold_full, hold_full_nx;
   logic [2:0]  hold_addr, eng_addr, eng_addr_nx;
   logic [31:0] hold_data, eng_data, eng_data_nx;
   logic        accept, transfer;
   logic        frame_n_nx, valid_n_nx, dout_nx, busy_nx;

   assign accept = in_valid && in_ready;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nx    = state;
      cnt_nx      = cnt + 6'd1;
      transfer    = 1'b0;
      eng_addr_nx = eng_addr;
      eng_data_nx = eng_data;

      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (hold_full) begin
               transfer = 1'b1;
               state_nx = ADDR;
            end
         end
         ADDR: begin
            if (cnt == 6'd2) begin
               cnt_nx = '0;
               if (PAD_CYCLES > 0) state_nx = PAD;
               else                state_nx = DATA;
            end
         end
         PAD: begin
            if (cnt == PAD_LAST) begin
               cnt_nx   = '0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (cnt == 6'd31) begin
               cnt_nx   = '0;
               state_nx = GAP;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx = '0;
               if (hold_full) begin
                  transfer = 1'b1;
                  state_nx = ADDR;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase

      // Engine shifts LSB-first; the bit on dout is always bit 0 of the next-cycle engine value.
      if (transfer) begin
         eng_addr_nx = hold_addr;
         eng_data_nx = hold_data;
      end else if (state == ADDR) begin
         eng_addr_nx = {1'b0, eng_addr[2:1]};
      end else if (state == DATA) begin
         eng_data_nx = {1'b0, eng_data[31:1]};
      end

      frame_n_nx = 1'b1;
      valid_n_nx = 1'b1;
      dout_nx    = 1'b0;
      unique case (state_nx)
         ADDR: begin
            frame_n_nx = 1'b0;
            dout_nx    = eng_addr_nx[0];
         end
         PAD: frame_n_nx = 1'b0;
         DATA: begin
            frame_n_nx = (cnt_nx == 6'd31);
            valid_n_nx = 1'b0;
            dout_nx    = eng_data_nx[0];
         end
         default: ;
      endcase

      hold_full_nx = hold_full;
      if (accept)        hold_full_nx = 1'b1;
      else if (transfer) hold_full_nx = 1'b0;

      busy_nx = (state_nx != IDLE) || hold_full_nx;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         hold_full <= 1'b0;
         in_ready  <= 1'b1;
         frame_n   <= 1'b1;
         valid_n   <= 1'b1;
         dout      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         hold_full <= hold_full_nx;
         in_ready  <= !hold_full_nx;
         frame_n   <= frame_n_nx;
         valid_n   <= valid_n_nx;
         dout      <= dout_nx;
         busy      <= busy_nx;
      end
   end

   // NOTE: payload registers are only read when hold_full/state qualify them, so they carry no reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         hold_addr <= in_addr;
         hold_data <= in_data;
      end
      eng_addr <= eng_addr_nx;
      eng_data <= eng_data_nx;
   end

`ifdef EGRESS_STATS_EN
   logic last_gap;
   assign last_gap = (state == GAP) && (cnt == GAP_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         pkt_count <= '0;
      else if (last_gap) pkt_count <= pkt_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_egress_serializer.sv
// Directed bench for egress_serializer: table of single packets plus back-to-back,
// backpressure, padding, mid-payload reset and (with EGRESS_STATS_EN) packet counting.
module tb_egress_serializer;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [2:0]  in_addr;
   logic [31:0] in_data;
   logic        sel;

   logic dv, pv;
   logic in_ready, frame_n, valid_n, dout, busy;
   logic p_in_ready, p_frame_n, p_valid_n, p_dout, p_busy;
   logic m_in_ready, m_frame_n, m_valid_n, m_dout, m_busy;
`ifdef EGRESS_STATS_EN
   logic [15:0] pkt_count, p_pkt_count;
`endif

   assign dv         = in_valid & ~sel;
   assign pv         = in_valid & sel;
   assign m_in_ready = sel ? p_in_ready : in_ready;
   assign m_frame_n  = sel ? p_frame_n  : frame_n;
   assign m_valid_n  = sel ? p_valid_n  : valid_n;
   assign m_dout     = sel ? p_dout     : dout;
   assign m_busy     = sel ? p_busy     : busy;

   egress_serializer #(.PAD_CYCLES(0), .GAP_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .in_valid(dv), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .frame_n(frame_n), .valid_n(valid_n),
      .dout(dout), .busy(busy)
`ifdef EGRESS_STATS_EN
      , .pkt_count(pkt_count)
`endif
   );

   egress_serializer #(.PAD_CYCLES(3), .GAP_CYCLES(2)) dut_pad (
      .clock(clock), .reset(reset), .in_valid(pv), .in_ready(p_in_ready),
      .in_addr(in_addr), .in_data(in_data), .frame_n(p_frame_n), .valid_n(p_valid_n),
      .dout(p_dout), .busy(p_busy)
`ifdef EGRESS_STATS_EN
      , .pkt_count(p_pkt_count)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge number.
   task automatic offer(input logic [2:0] a, input logic [31:0] d, input string tag, output int acc);
      bit done;
      done     = 1'b0;
      acc      = -1;
      in_addr  = a;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (m_in_ready) begin
            @(posedge clock);
            @(negedge clock);
            acc  = cyc;
            done = 1'b1;
         end else begin
            @(negedge clock);
         end
      end
      if (!done) timeout_fail({tag, " accept"});
   endtask

   // Waits for a frame and compares every cycle of it against the serial format.
   task automatic watch(input logic [2:0] ea, input logic [31:0] ed, input int pad, input string tag,
                        output int start, output int idle, output int nf, output int nv);
      int          bad, j;
      logic [2:0]  ga;
      logic [31:0] gd;
      logic        ef, ev, eb;
      bit          seen;
      bad = 0; ga = '0; gd = '0; seen = 1'b0;
      start = -1; idle = 0; nf = 0; nv = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clock);
         if (!m_frame_n)    seen = 1'b1;
         else if (m_valid_n) idle++;
      end
      if (!seen) begin
         timeout_fail({tag, " frame start"});
         return;
      end
      start = cyc;
      for (int k = 1; k <= 35 + pad; k++) begin
         if (k > 1) @(negedge clock);
         j = k - 4 - pad;
         if (k <= 3) begin
            ef = 1'b0; ev = 1'b1; eb = ea[k-1];
            ga[k-1] = m_dout;
         end else if (j < 0) begin
            ef = 1'b0; ev = 1'b1; eb = 1'b0;
         end else begin
            ef = (j == 31); ev = 1'b0; eb = ed[j];
            gd[j] = m_dout;
         end
         if (m_frame_n !== ef || m_valid_n !== ev || m_dout !== eb) bad++;
         if (!m_frame_n) nf++;
         if (!m_valid_n) nv++;
      end
      check({tag, " bad cycles"}, 64'(bad), 64'd0);
      check({tag, " addr"}, 64'(ga), 64'(ea));
      check({tag, " data"}, 64'(gd), 64'(ed));
   endtask

   task automatic tail(input string tag);
      int idle_ok;
      idle_ok = 0;
      repeat (2) begin
         @(negedge clock);
         if (m_frame_n === 1'b1 && m_valid_n === 1'b1 && m_dout === 1'b0) idle_ok++;
      end
      check({tag, " gap idle cycles"}, 64'(idle_ok), 64'd2);
      @(negedge clock);
      check({tag, " busy after gap"}, 64'(m_busy), 64'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic [2:0]  exp_addr;
      logic [31:0] exp_data;
      int          exp_nf;
      int          exp_nv;
   } vec_t;

   vec_t vecs [4];
   int acc, acc2, st, idle, nf, nv;
   int a1, a2, a3, s1, s2, s3, i1, i2, i3, f1, f2, f3, v1, v2, v3;

   initial begin
      vecs[0] = '{3'b101, 32'hA5A5_0001, 3'd5, 32'hA5A5_0001, 34, 32};
      vecs[1] = '{3'b000, 32'h0000_0000, 3'd0, 32'h0000_0000, 34, 32};
      vecs[2] = '{3'b111, 32'hFFFF_FFFF, 3'd7, 32'hFFFF_FFFF, 34, 32};
      vecs[3] = '{3'b100, 32'h8000_0001, 3'd4, 32'h8000_0001, 34, 32};

      reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; sel = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("reset frame_n", 64'(frame_n), 64'd1);
      check("reset valid_n", 64'(valid_n), 64'd1);
      check("reset dout", 64'(dout), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 4; i++) begin
         offer(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i), acc);
         in_valid = 1'b0;
         watch(vecs[i].exp_addr, vecs[i].exp_data, 0, $sformatf("vec%0d", i), st, idle, nf, nv);
         check($sformatf("vec%0d latency", i), 64'(st - acc), 64'd1);
         check($sformatf("vec%0d frame_n low cycles", i), 64'(nf), 64'(vecs[i].exp_nf));
         check($sformatf("vec%0d valid_n low cycles", i), 64'(nv), 64'(vecs[i].exp_nv));
         tail($sformatf("vec%0d", i));
      end

      fork
         begin
            offer(3'd2, 32'h0000_FFFF, "b2b1", a1);
            offer(3'd6, 32'h8000_0000, "b2b2", a2);
            in_valid = 1'b0;
         end
         begin
            watch(3'd2, 32'h0000_FFFF, 0, "b2b1", s1, i1, f1, v1);
            watch(3'd6, 32'h8000_0000, 0, "b2b2", s2, i2, f2, v2);
         end
      join
      check("b2b second accept after ADDR entry", 64'(a2 - s1), 64'd1);
      check("b2b idle between frames", 64'(i2), 64'd2);
      check("b2b frame period", 64'(s2 - s1), 64'd37);
      tail("b2b");

      fork
         begin
            offer(3'd1, 32'h1234_5678, "bp1", a1);
            offer(3'd3, 32'hDEAD_BEEF, "bp2", a2);
            check("bp in_ready low while hold full", 64'(m_in_ready), 64'd0);
            offer(3'd0, 32'h0F0F_F0F0, "bp3", a3);
            in_valid = 1'b0;
         end
         begin
            watch(3'd1, 32'h1234_5678, 0, "bp1", s1, i1, f1, v1);
            watch(3'd3, 32'hDEAD_BEEF, 0, "bp2", s2, i2, f2, v2);
            watch(3'd0, 32'h0F0F_F0F0, 0, "bp3", s3, i3, f3, v3);
         end
      join
      check("bp third accept after second starts", 64'(a3 - s2), 64'd1);
      check("bp idle before third", 64'(i3), 64'd2);
      tail("bp");

      @(negedge clock);
      sel = 1'b1;
      offer(3'b011, 32'h1357_9BDF, "pad", acc);
      in_valid = 1'b0;
      watch(3'b011, 32'h1357_9BDF, 3, "pad", st, idle, nf, nv);
      check("pad latency", 64'(st - acc), 64'd1);
      check("pad frame_n low cycles", 64'(nf), 64'd37);
      check("pad valid_n low cycles", 64'(nv), 64'd32);
      tail("pad");
`ifdef EGRESS_STATS_EN
      check("pad instance pkt_count", 64'(p_pkt_count), 64'd1);
`endif
      @(negedge clock);
      sel = 1'b0;

`ifdef EGRESS_STATS_EN
      pulse_reset();
      check("stats cleared by reset", 64'(pkt_count), 64'd0);
      for (int i = 0; i < 3; i++) begin
         offer(vecs[i].addr, vecs[i].data, $sformatf("stats%0d", i), acc);
         in_valid = 1'b0;
         watch(vecs[i].exp_addr, vecs[i].exp_data, 0, $sformatf("stats%0d", i), st, idle, nf, nv);
         tail($sformatf("stats%0d", i));
      end
      check("stats count after 3 packets", 64'(pkt_count), 64'd3);
`endif

      @(negedge clock);
      offer(3'd1, 32'hCAFE_0400, "rstA", acc);
      offer(3'd6, 32'h1111_2222, "rstB", acc2);
      in_valid = 1'b0;
      repeat (12) @(negedge clock);
      check("rst bit10 valid_n", 64'(valid_n), 64'd0);
      check("rst bit10 dout", 64'(dout), 64'd1);
`ifdef EGRESS_STATS_EN
      check("rst pkt_count before reset", 64'(pkt_count), 64'd3);
`endif
      #1 reset = 1'b1;
      #1;
      check("rst frame_n immediate", 64'(frame_n), 64'd1);
      check("rst valid_n immediate", 64'(valid_n), 64'd1);
      check("rst dout immediate", 64'(dout), 64'd0);
      check("rst in_ready immediate", 64'(in_ready), 64'd1);
      check("rst busy immediate", 64'(busy), 64'd0);
`ifdef EGRESS_STATS_EN
      check("rst pkt_count after reset", 64'(pkt_count), 64'd0);
`endif
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst hold emptied busy", 64'(busy), 64'd0);
      check("rst no stale frame", 64'(frame_n), 64'd1);

      offer(3'd4, 32'h0BAD_F00D, "post", acc);
      in_valid = 1'b0;
      watch(3'd4, 32'h0BAD_F00D, 0, "post", st, idle, nf, nv);
      check("post latency", 64'(st - acc), 64'd1);
      tail("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
